// File: rtl/snax_dimc_stream_upsizer.sv
// Narrow-to-wide stream packer that feeds a DIMC stream2acc port.
// It gathers Ratio narrow beats (or fewer when a last beat arrives early) into one zero-padded wide word.
module snax_dimc_stream_upsizer #(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned WideDataWidth   = 512,
  localparam int unsigned Ratio          = WideDataWidth / NarrowDataWidth,
  localparam int unsigned LaneIdxWidth   = (Ratio > 1) ? $clog2(Ratio) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NarrowDataWidth-1:0] narrow_data_i,
  input  logic                       narrow_valid_i,
  input  logic                       narrow_last_i,
  output logic                       narrow_ready_o,
  input  logic                       clear_i,
  output logic [WideDataWidth-1:0]   stream2acc_data_o,
  output logic                       stream2acc_valid_o,
  input  logic                       stream2acc_ready_i,
  output logic                       stream2acc_last_o,
  output logic [15:0]                word_cnt_o
);

  localparam logic [LaneIdxWidth-1:0] LastLane = LaneIdxWidth'(Ratio - 1);

  // Handshakes on both sides are valid/ready: a transfer happens on a rising
  // clk_i edge where valid and ready are both high; valid never waits on ready,
  // and clear_i cancels any transfer that would otherwise happen in its cycle.

  logic [LaneIdxWidth-1:0]  lane_idx_q, lane_idx_d;
  logic [WideDataWidth-1:0] pack_q, pack_d;
  logic [WideDataWidth-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [15:0]              word_cnt_q, word_cnt_d;

  logic                     accept;
  logic                     complete;
  logic                     handshake;
  logic [WideDataWidth-1:0] merged;

  // The ready path is kept off narrow_valid_i/narrow_last_i on purpose.
  assign narrow_ready_o = !out_valid_q || stream2acc_ready_i;

  assign accept    = narrow_valid_i && narrow_ready_o && !clear_i;
  assign complete  = accept && ((lane_idx_q == LastLane) || narrow_last_i);
  assign handshake = out_valid_q && stream2acc_ready_i && !clear_i;

  // Lanes above the current index are always zero in pack_q, which gives the zero padding on early flush.
  always_comb begin
    merged = pack_q;
    for (int k = 0; k < Ratio; k++) begin
      if (lane_idx_q == LaneIdxWidth'(k)) begin
        merged[k*NarrowDataWidth +: NarrowDataWidth] = narrow_data_i;
      end
    end
  end

  always_comb begin
    lane_idx_d  = lane_idx_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    word_cnt_d  = word_cnt_q;

    if (clear_i) begin
      lane_idx_d  = '0;
      pack_d      = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      word_cnt_d  = '0;
    end else begin
      if (handshake) begin
        out_valid_d = 1'b0;
        word_cnt_d  = word_cnt_q + 16'd1;
      end
      if (accept) begin
        if (complete) begin
          // A completion in the handshake cycle reloads the output, keeping valid high.
          out_data_d  = merged;
          out_last_d  = narrow_last_i;
          out_valid_d = 1'b1;
          lane_idx_d  = '0;
          pack_d      = '0;
        end else begin
          pack_d     = merged;
          lane_idx_d = lane_idx_q + LaneIdxWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_idx_q  <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      lane_idx_q  <= lane_idx_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign stream2acc_data_o  = out_data_q;
  assign stream2acc_valid_o = out_valid_q;
  assign stream2acc_last_o  = out_last_q;
  assign word_cnt_o         = word_cnt_q;

endmodule

// File: tb/tb_snax_dimc_stream_upsizer.sv
// Directed plus randomized bench for snax_dimc_stream_upsizer, checked against a beat-queue reference model.
module tb_snax_dimc_stream_upsizer;

  localparam int N = 64;
  localparam int W = 512;
  localparam int R = W / N;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]  narrow_data;
  logic          narrow_valid = 1'b0;
  logic          narrow_last  = 1'b0;
  logic          narrow_ready;
  logic          clear        = 1'b0;
  logic [W-1:0]  s2a_data;
  logic          s2a_valid;
  logic          s2a_ready    = 1'b0;
  logic          s2a_last;
  logic [15:0]   word_cnt;

  snax_dimc_stream_upsizer #(
    .NarrowDataWidth(N),
    .WideDataWidth  (W)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .narrow_data_i     (narrow_data),
    .narrow_valid_i    (narrow_valid),
    .narrow_last_i     (narrow_last),
    .narrow_ready_o    (narrow_ready),
    .clear_i           (clear),
    .stream2acc_data_o (s2a_data),
    .stream2acc_valid_o(s2a_valid),
    .stream2acc_ready_i(s2a_ready),
    .stream2acc_last_o (s2a_last),
    .word_cnt_o        (word_cnt)
  );

  // scoreboard: beats of the word being built, and completed words awaiting handoff
  logic [N-1:0] beats_q[$];
  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  logic [15:0]  exp_cnt = '0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    beats_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    exp_cnt = '0;
  endtask

  // One clock cycle, entered and left at a negedge: drive, check, update model, clock.
  task automatic cycle(input logic v, input logic [N-1:0] d, input logic l,
                       input logic rdy, input logic clr);
    logic         exp_ready;
    logic         acc;
    logic         hs;
    logic [W-1:0] word;
    narrow_valid = v;
    narrow_data  = d;
    narrow_last  = l;
    s2a_ready    = rdy;
    clear        = clr;
    #1;
    exp_ready = (exp_q.size() == 0) || rdy;
    check("narrow_ready", W'(narrow_ready), W'(exp_ready));
    check("valid", W'(s2a_valid), W'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("data", s2a_data, exp_q[0]);
      check("last", W'(s2a_last), W'(exp_last_q[0]));
    end
    check("word_cnt", W'(word_cnt), W'(exp_cnt));
    if (clr) begin
      model_reset();
    end else begin
      acc = v && exp_ready;
      hs  = (exp_q.size() != 0) && rdy;
      if (hs) begin
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
      if (acc) begin
        beats_q.push_back(d);
        if (beats_q.size() == R || l) begin
          word = '0;
          foreach (beats_q[k]) word[k*N +: N] = beats_q[k];
          exp_q.push_back(word);
          exp_last_q.push_back(l);
          beats_q.delete();
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  logic [W-1:0] t_word;
  logic [W-1:0] held;
  logic [15:0]  cnt_before;

  initial begin
    narrow_data = '0;
    // reset state
    #12;
    check("rst_valid", W'(s2a_valid), '0);
    check("rst_data", s2a_data, '0);
    check("rst_last", W'(s2a_last), '0);
    check("rst_cnt", W'(word_cnt), '0);
    check("rst_ready", W'(narrow_ready), W'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: full word of beats 1..8
    for (int k = 0; k < R; k++) cycle(1'b1, N'(k + 1), 1'b0, 1'b1, 1'b0);
    t_word = '0;
    for (int k = 0; k < R; k++) t_word[k*N +: N] = N'(k + 1);
    check("t1_valid", W'(s2a_valid), W'(1'b1));
    check("t1_data", s2a_data, t_word);
    check("t1_last", W'(s2a_last), '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t1_cnt", W'(word_cnt), W'(16'd1));

    // 2: backpressure
    for (int k = 0; k < R; k++) cycle(1'b1, rnd64(), 1'b0, 1'b0, 1'b0);
    held = s2a_data;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 64'h99, 1'b0, 1'b0, 1'b0);
      check("t2_stable", s2a_data, held);
    end
    cycle(1'b1, 64'h99, 1'b0, 1'b1, 1'b0);
    check("t2_cnt", W'(word_cnt), W'(16'd2));
    check("t2_drained", W'(s2a_valid), '0);
    for (int k = 1; k < R; k++) cycle(1'b1, N'(k), 1'b0, 1'b1, 1'b0);
    t_word = '0;
    t_word[N-1:0] = 64'h99;
    for (int k = 1; k < R; k++) t_word[k*N +: N] = N'(k);
    check("t2_9th_lane0", s2a_data, t_word);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // 3: partial flush
    cycle(1'b1, 64'hA, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 64'hB, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 64'hC, 1'b1, 1'b1, 1'b0);
    t_word = '0;
    t_word[N-1:0] = 64'hA; t_word[N +: N] = 64'hB; t_word[2*N +: N] = 64'hC;
    check("t3_data", s2a_data, t_word);
    check("t3_last", W'(s2a_last), W'(1'b1));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);  // last ignored without valid
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < R; k++) cycle(1'b1, N'(8'hD0 + k), k == R - 1, 1'b1, 1'b0);
    check("t3_full_last", W'(s2a_last), W'(1'b1));
    check("t3_lane0", W'(s2a_data[N-1:0]), W'(64'hD0));
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // 4: streaming 64 beats
    cnt_before = word_cnt;
    for (int k = 0; k < 64; k++) cycle(1'b1, rnd64(), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t4_words", W'(word_cnt - cnt_before), W'(16'd8));

    // 5: clear mid-word and async reset mid-word
    for (int k = 0; k < 5; k++) cycle(1'b1, 64'hEE, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 64'hEE, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < R; k++) cycle(1'b1, N'(k + 16), 1'b0, 1'b0, 1'b0);
    t_word = '0;
    for (int k = 0; k < R; k++) t_word[k*N +: N] = N'(k + 16);
    check("t5_clean", s2a_data, t_word);
    check("t5_cnt0", W'(word_cnt), '0);
    cycle(1'b1, 64'h5, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 64'h6, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", W'(s2a_valid), '0);
    check("t5_rst_data", s2a_data, '0);
    check("t5_rst_cnt", W'(word_cnt), '0);
    check("t5_rst_ready", W'(narrow_ready), W'(1'b1));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cycle(1'b1, N'(k + 32), k == 2, 1'b0, 1'b0);
    t_word = '0;
    for (int k = 0; k < 3; k++) t_word[k*N +: N] = N'(k + 32);
    check("t5_post_rst", s2a_data, t_word);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // randomized traffic with random backpressure, last and clear
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(0, 3) != 0, rnd64(), $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end

    // 6: counter wrap
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 65536; k++) cycle(1'b1, rnd64(), 1'b1, 1'b1, 1'b0);
    check("t6_cnt_ffff", W'(word_cnt), W'(16'hFFFF));
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t6_cnt_wrap", W'(word_cnt), W'(16'h0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snax_dimc_stream_upsizer.md
Name: snax_dimc_stream_upsizer

Overview:
Narrow-to-wide stream packer directly upstream of a DIMC accelerator stream2acc input port. It collects WideDataWidth/NarrowDataWidth narrow beats from a narrow producer into one wide word. It presents that word on a valid/ready interface that connects one-to-one to stream2acc_N_data_i/valid_i/ready_o. It supports early flush of partial words (zero-padded), a synchronous clear, and a wrapping emitted-word counter for debug CSRs.

Parameters:
NarrowDataWidth, 64, width of one input beat (bits)
WideDataWidth, 512, width of output word; must be an integer multiple of NarrowDataWidth
Ratio, WideDataWidth/NarrowDataWidth (8), lanes per wide word; derived, not overridden
LaneIdxWidth, $clog2(Ratio) (3), lane index width; derived

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
narrow_data_i  in  NarrowDataWidth  input beat
narrow_valid_i  in  1  input beat valid
narrow_last_i  in  1  qualifies beat as last of a word; forces flush of current word
narrow_ready_o  out  1  input beat accepted when valid&ready
clear_i  in  1  synchronous clear of all state
stream2acc_data_o  out  WideDataWidth  packed wide word
stream2acc_valid_o  out  1  wide word valid
stream2acc_ready_i  in  1  downstream (accelerator) ready
stream2acc_last_o  out  1  word was closed by narrow_last_i (may be partial)
word_cnt_o  out  16  count of wide words handed off (valid&ready), wraps

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: stream2acc_valid_o=0, stream2acc_data_o=0, stream2acc_last_o=0, word_cnt_o=0, internal lane index=0, pack register=0. narrow_ready_o is 1 after reset, since the output register is empty.
- Storage: one pack register (Ratio lanes plus lane index) and one output register (data, last, valid).
- Lane order: the k-th accepted beat of a word goes to bits [k*NarrowDataWidth +: NarrowDataWidth]. Lane 0 holds the LSBs and is the first beat.
- narrow_ready_o = !stream2acc_valid_o || stream2acc_ready_i. It is purely a function of output-side state and stream2acc_ready_i. There is no combinational path from narrow_valid_i or narrow_last_i.
- Accept: a beat is accepted when narrow_valid_i && narrow_ready_o && !clear_i. On accept it is written to the lane at the current lane index.
- Completion: an accepted beat completes the word if the lane index is Ratio-1 or narrow_last_i=1. On completion, on the same edge:
  - the packed word, including the current beat, moves into the output register;
  - lanes above the current index are zero in the output;
  - stream2acc_last_o is set to narrow_last_i;
  - stream2acc_valid_o is set to 1;
  - the lane index returns to 0 and the pack register is cleared.
- Non-completing accept: the lane index increments by 1.
- Latency: the wide word is valid in the cycle after its completing beat is accepted.
- Throughput: 1 narrow beat/cycle sustained while stream2acc_ready_i=1.
- Output handshake: data, last and valid are held stable while valid=1 and ready=0.
  - On valid&ready with no new completion, valid drops to 0 on the next edge.
  - On valid&ready plus a completion in the same cycle, the register reloads with the new word and valid stays 1.
- word_cnt_o increments on each output handshake and wraps 0xFFFF→0x0000.
- clear_i (synchronous) has priority over accept and handshake in the same cycle. It zeroes the lane index, pack register, output register (valid=0, last=0) and word_cnt_o. A beat presented in that cycle is dropped and does not count as a handshake, even though narrow_ready_o may be 1.
- Asynchronous reset mid-word or mid-handshake discards all state immediately. There is no partial output.
- narrow_last_i is ignored when narrow_valid_i=0.
- A last beat landing in lane Ratio-1 yields a full word with last=1.

Test Plan:
1. Full word: ready_i=1; feed beats 0x1..0x8, one per cycle → one cycle after the 8th accept, valid=1 with lane k = k+1, last=0; after the handshake word_cnt_o=1.
2. Backpressure: complete a word with ready_i=0, then offer a 9th beat → narrow_ready_o=0, output data stable for 10 cycles. Raise ready_i → handshake, and the 9th beat is accepted in the same cycle.
3. Partial flush: beats 0xA,0xB,0xC with last on 0xC → lanes 0-2 = A,B,C, lanes 3-7 = 0, last_o=1. The next beat lands in lane 0.
4. Streaming: 64 back-to-back beats with ready_i held 1 → 8 words on consecutive-beat cadence, narrow_ready_o never 0, word_cnt_o=8.
5. Clear and reset: clear_i after 5 beats, then 8 beats → clean word with no stale lanes, word_cnt_o restarts at 0. Async rst_i pulse mid-word → all outputs 0 before the next clk edge.
6. Counter wrap: preload via 65535 handshakes, then one more → word_cnt_o=0x0000.
